// File: rtl/alu_multicycle_if.sv
// ---------------------------------------------------------------------------
// alu_multicycle_if
// Purpose : Bundles the request/response signals between the execute-stage
//           sequencer (master) and the multi-cycle ALU (slave).
// Signals :
//   aluOp       4      operation code (master -> slave)
//   aluStart    1      request strobe (master -> slave)
//   carryIn     1      carry/borrow-in for ADC/SBB (master -> slave)
//   operandA    WIDTH  A operand (master -> slave)
//   operandB    WIDTH  B operand / shift amount (master -> slave)
//   aluResult   WIDTH  registered result (slave -> master)
//   aluCarry    1      registered carry flag (slave -> master)
//   aluOverflow 1      registered overflow flag (slave -> master)
//   aluError    1      registered illegal-op flag (slave -> master)
//   aluBusy     1      multi-cycle op in progress (slave -> master)
//   aluDone     1      one-cycle completion pulse (slave -> master)
// ---------------------------------------------------------------------------
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       aluOp;
    logic             aluStart;
    logic             carryIn;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [WIDTH-1:0] aluResult;
    logic             aluCarry;
    logic             aluOverflow;
    logic             aluError;
    logic             aluBusy;
    logic             aluDone;

    // The sequencer issues requests and watches the handshake.
    modport master (
        output aluOp, aluStart, carryIn, operandA, operandB,
        input  aluResult, aluCarry, aluOverflow, aluError, aluBusy, aluDone
    );

    // The ALU consumes requests and produces registered results.
    modport slave (
        input  aluOp, aluStart, carryIn, operandA, operandB,
        output aluResult, aluCarry, aluOverflow, aluError, aluBusy, aluDone
    );
endinterface

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// Purpose : Execute-stage ALU with a start/done handshake. Add/sub/logic ops
//           and illegal opcodes complete in one cycle without raising busy;
//           shifts iterate one bit per cycle and the optional multiplier is
//           an unsigned shift-add over WIDTH cycles. Results and flags are
//           registered and held until the next completion.
// Ports   :
//   clk      in  1   rising-edge clock
//   reset_n  in  1   asynchronous active-low reset; aborts any op in flight
//   aluBus   slave modport of alu_multicycle_if (operands, op, handshake,
//            result and flags)
// Config  : define ALU_MUL_EN to build the iterative multiplier; without it
//           opcode 11 is treated as illegal and no multiplier logic exists.
// ---------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_multicycle_if.slave   aluBus
);

    localparam int SHAMT_W = $clog2(WIDTH);
    // One extra bit so the counter can hold WIDTH for the multiplier.
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_err;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_bSel;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_addOvf;

    logic [WIDTH-1:0] w_quickResult;
    logic             w_quickCarry;
    logic             w_quickOvf;
    logic             w_quickErr;
    logic             w_isMulti;

    logic [WIDTH-1:0] w_shNext;
    logic             w_shOut;

    // Shared adder for ADD/ADC/SUB/SBB. Subtraction inverts B and uses the
    // carry-in as "not borrow", so carry-out = 1 means no borrow occurred.
    always_comb begin
        w_bSel = ((aluBus.aluOp == OP_SUB) || (aluBus.aluOp == OP_SBB))
                 ? ~aluBus.operandB : aluBus.operandB;
        case (aluBus.aluOp)
            OP_ADC:  w_cin = aluBus.carryIn;
            OP_SUB:  w_cin = 1'b1;
            OP_SBB:  w_cin = aluBus.carryIn;
            default: w_cin = 1'b0;
        endcase
        w_sum = {1'b0, aluBus.operandA} + {1'b0, w_bSel} + {{WIDTH{1'b0}}, w_cin};
        w_addOvf = (~aluBus.operandA[WIDTH-1] & ~w_bSel[WIDTH-1] &  w_sum[WIDTH-1]) |
                   ( aluBus.operandA[WIDTH-1] &  w_bSel[WIDTH-1] & ~w_sum[WIDTH-1]);
    end

    // Decode of the incoming request: single-cycle ops produce their final
    // outputs here, multi-cycle ops only flag that the EXEC phase is needed.
    always_comb begin
        w_quickResult = '0;
        w_quickCarry  = 1'b0;
        w_quickOvf    = 1'b0;
        w_quickErr    = 1'b0;
        w_isMulti     = 1'b0;
        case (aluBus.aluOp)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                w_quickResult = w_sum[WIDTH-1:0];
                w_quickCarry  = w_sum[WIDTH];
                w_quickOvf    = w_addOvf;
            end
            OP_AND: w_quickResult = aluBus.operandA & aluBus.operandB;
            OP_OR:  w_quickResult = aluBus.operandA | aluBus.operandB;
            OP_XOR: w_quickResult = aluBus.operandA ^ aluBus.operandB;
            OP_NOT: w_quickResult = ~aluBus.operandB;
            OP_SHL, OP_SHR, OP_SAR: w_isMulti = 1'b1;
`ifdef ALU_MUL_EN
            OP_MUL: w_isMulti = 1'b1;
`else
            OP_MUL: w_quickErr = 1'b1;
`endif
            default: w_quickErr = 1'b1;
        endcase
    end

    // One-bit shift step on the working register; the bit leaving the
    // register becomes the carry if this is the final step.
    always_comb begin
        w_shNext = r_work;
        w_shOut  = 1'b0;
        case (r_op)
            OP_SHL: begin
                w_shNext = {r_work[WIDTH-2:0], 1'b0};
                w_shOut  = r_work[WIDTH-1];
            end
            OP_SHR: begin
                w_shNext = {1'b0, r_work[WIDTH-1:1]};
                w_shOut  = r_work[0];
            end
            default: begin
                w_shNext = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                w_shOut  = r_work[0];
            end
        endcase
    end

`ifdef ALU_MUL_EN
    // Shift-add multiplier: upper half accumulates partial sums, lower half
    // holds the not-yet-consumed multiplier bits. Each step conditionally
    // adds the multiplicand (r_work) and shifts the whole pair right.
    logic [2*WIDTH-1:0] r_mulAcc;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;

    always_comb begin
        w_mulSum  = {1'b0, r_mulAcc[2*WIDTH-1:WIDTH]} +
                    (r_mulAcc[0] ? {1'b0, r_work} : {(WIDTH+1){1'b0}});
        w_mulNext = {w_mulSum, r_mulAcc[WIDTH-1:1]};
    end
`endif

    // Control FSM and all registered outputs. IDLE accepts a request every
    // cycle; single-cycle ops complete straight from IDLE, multi-cycle ops
    // spend their iterations in EXEC and return to IDLE on the cycle that
    // publishes the result, so a new start can be taken in the done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op     <= 4'd0;
            r_work   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef ALU_MUL_EN
            r_mulAcc <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (aluBus.aluStart) begin
                        r_op   <= aluBus.aluOp;
                        r_work <= aluBus.operandA;
                        if (w_isMulti) begin
                            r_state <= S_EXEC;
                            r_busy  <= 1'b1;
`ifdef ALU_MUL_EN
                            if (aluBus.aluOp == OP_MUL) begin
                                r_count  <= CNT_W'(WIDTH);
                                r_mulAcc <= {{WIDTH{1'b0}}, aluBus.operandB};
                            end else
`endif
                            r_count <= {1'b0, aluBus.operandB[SHAMT_W-1:0]};
                        end else begin
                            r_result <= w_quickResult;
                            r_carry  <= w_quickCarry;
                            r_ovf    <= w_quickOvf;
                            r_err    <= w_quickErr;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
`ifdef ALU_MUL_EN
                    if (r_op == OP_MUL) begin
                        r_mulAcc <= w_mulNext;
                        r_count  <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_mulNext[WIDTH-1:0];
                            r_carry  <= |w_mulNext[2*WIDTH-1:WIDTH];
                            r_ovf    <= |w_mulNext[2*WIDTH-1:WIDTH];
                            r_err    <= 1'b0;
                        end
                    end else
`endif
                    // A zero shift amount still spends one EXEC cycle and
                    // passes A through with a clear carry.
                    if (r_count == '0) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= r_work;
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b0;
                    end else if (r_count == CNT_W'(1)) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_shNext;
                        r_carry  <= w_shOut;
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b0;
                    end else begin
                        r_work  <= w_shNext;
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign aluBus.aluResult   = r_result;
    assign aluBus.aluCarry    = r_carry;
    assign aluBus.aluOverflow = r_ovf;
    assign aluBus.aluError    = r_err;
    assign aluBus.aluBusy     = r_busy;
    assign aluBus.aluDone     = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
// Purpose : Directed self-checking bench for alu_multicycle (WIDTH=32).
//           Expected values are hand-computed constants. Inputs are driven
//           on the falling edge, outputs sampled on the falling edge.
//           Define ALU_MUL_EN to expect the multiplier build.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(WIDTH)) aluBus ();

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .aluBus  (aluBus)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compares the full registered output set after a completion.
    task automatic checkFlags(input string tag, input logic [31:0] expResult,
                              input logic expCarry, input logic expOvf, input logic expErr);
        checkOutput({tag, ".result"}, aluBus.aluResult, expResult);
        checkOutput({tag, ".carry"},  aluBus.aluCarry,  expCarry);
        checkOutput({tag, ".ovf"},    aluBus.aluOverflow, expOvf);
        checkOutput({tag, ".err"},    aluBus.aluError,  expErr);
        checkOutput({tag, ".busy"},   aluBus.aluBusy,   1'b0);
    endtask

    // Issues one request and waits (bounded) for aluDone. latency is the
    // number of cycles from the accepting edge to the done cycle, 0 on timeout.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin,
                                 input int budget, output int latency);
        @(negedge clk);
        aluBus.aluOp    = op;
        aluBus.operandA = a;
        aluBus.operandB = b;
        aluBus.carryIn  = cin;
        aluBus.aluStart = 1'b1;
        @(posedge clk);
        #1;
        aluBus.aluStart = 1'b0;
        latency = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (aluBus.aluDone) begin
                latency = c;
                break;
            end
        end
    endtask

    int lat;
    int doneSeen;

    initial begin
        reset_n         = 1'b0;
        aluBus.aluStart = 1'b0;
        aluBus.aluOp    = 4'd0;
        aluBus.operandA = '0;
        aluBus.operandB = '0;
        aluBus.carryIn  = 1'b0;
        #2;
        checkOutput("reset.result", aluBus.aluResult, 0);
        checkOutput("reset.carry",  aluBus.aluCarry, 0);
        checkOutput("reset.ovf",    aluBus.aluOverflow, 0);
        checkOutput("reset.err",    aluBus.aluError, 0);
        checkOutput("reset.busy",   aluBus.aluBusy, 0);
        checkOutput("reset.done",   aluBus.aluDone, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // SUB 5-7: borrow means carry=0
        applyStimulus(4'd2, 32'd5, 32'd7, 1'b0, 10, lat);
        checkOutput("sub.lat", lat, 1);
        checkFlags("sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // ADD then ADC back-to-back on consecutive edges
        @(negedge clk);
        aluBus.aluOp = 4'd0; aluBus.operandA = 32'h7FFF_FFFF; aluBus.operandB = 32'd1;
        aluBus.carryIn = 1'b0; aluBus.aluStart = 1'b1;
        @(posedge clk);
        #1;
        aluBus.aluOp = 4'd1; aluBus.operandA = 32'hFFFF_FFFF; aluBus.operandB = 32'd0;
        aluBus.carryIn = 1'b1;
        @(negedge clk);
        checkOutput("b2b.add.done", aluBus.aluDone, 1);
        checkFlags("b2b.add", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        aluBus.aluStart = 1'b0;
        @(negedge clk);
        checkOutput("b2b.adc.done", aluBus.aluDone, 1);
        checkFlags("b2b.adc", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        // Logic ops clear the carry left by ADC
        applyStimulus(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 10, lat);
        checkOutput("and.lat", lat, 1);
        checkFlags("and", 32'h00F0_1200, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 10, lat);
        checkFlags("or", 32'hFFF0_FF34, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 10, lat);
        checkFlags("xor", 32'hFF00_ED34, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 10, lat);
        checkFlags("not", 32'hF00F_00FF, 1'b0, 1'b0, 1'b0);

        // SBB with and without incoming borrow, SUB signed overflow
        applyStimulus(4'd3, 32'd5, 32'd3, 1'b1, 10, lat);
        checkFlags("sbb.c1", 32'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd3, 32'd5, 32'd3, 1'b0, 10, lat);
        checkFlags("sbb.c0", 32'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd2, 32'h8000_0000, 32'd1, 1'b0, 10, lat);
        checkFlags("sub.ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // SAR n=4 with an ignored start while busy
        @(negedge clk);
        aluBus.aluOp = 4'd10; aluBus.operandA = 32'h8000_0001; aluBus.operandB = 32'd4;
        aluBus.aluStart = 1'b1;
        @(posedge clk);
        #1;
        aluBus.aluStart = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("sar.busy%0d", c), aluBus.aluBusy, 1);
            checkOutput($sformatf("sar.done%0d", c), aluBus.aluDone, 0);
            if (c == 1) begin
                aluBus.aluOp = 4'd0; aluBus.operandA = 32'd1; aluBus.operandB = 32'd1;
                aluBus.aluStart = 1'b1;
            end else begin
                aluBus.aluStart = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("sar.done5", aluBus.aluDone, 1);
        checkFlags("sar", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sar.noQueue.done", aluBus.aluDone, 0);
        checkOutput("sar.noQueue.result", aluBus.aluResult, 32'hF800_0000);

        // Shift boundary cases
        applyStimulus(4'd8, 32'h1, 32'd0, 1'b0, 10, lat);
        checkOutput("shl0.lat", lat, 2);
        checkFlags("shl0", 32'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd9, 32'h3, 32'd1, 1'b0, 10, lat);
        checkOutput("shr1.lat", lat, 2);
        checkFlags("shr1", 32'h1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd8, 32'h8000_0001, 32'd1, 1'b0, 10, lat);
        checkFlags("shl1", 32'h2, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd9, 32'h8000_0000, 32'hFFFF_FF1F, 1'b0, 40, lat);
        checkOutput("shr31.lat", lat, 32);
        checkFlags("shr31", 32'h1, 1'b0, 1'b0, 1'b0);

        // Multiply
        applyStimulus(4'd11, 32'h0001_0000, 32'h0001_0000, 1'b0, 40, lat);
`ifdef ALU_MUL_EN
        checkOutput("mul.lat", lat, 33);
        checkFlags("mul", 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'd11, 32'd7, 32'd6, 1'b0, 40, lat);
        checkOutput("mul76.lat", lat, 33);
        checkFlags("mul76", 32'd42, 1'b0, 1'b0, 1'b0);
`else
        checkOutput("mul.lat", lat, 1);
        checkFlags("mul", 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd0, 32'd2, 32'd3, 1'b0, 10, lat);
        checkFlags("mul.clear", 32'd5, 1'b0, 1'b0, 1'b0);
`endif

        // Reset in the middle of SAR n=20
        @(negedge clk);
        aluBus.aluOp = 4'd10; aluBus.operandA = 32'h1234_5678; aluBus.operandB = 32'd20;
        aluBus.aluStart = 1'b1;
        @(posedge clk);
        #1;
        aluBus.aluStart = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort.result", aluBus.aluResult, 0);
        checkOutput("abort.carry",  aluBus.aluCarry, 0);
        checkOutput("abort.ovf",    aluBus.aluOverflow, 0);
        checkOutput("abort.err",    aluBus.aluError, 0);
        checkOutput("abort.busy",   aluBus.aluBusy, 0);
        checkOutput("abort.done",   aluBus.aluDone, 0);
        @(negedge clk);
        reset_n = 1'b1;
        doneSeen = 0;
        repeat (25) begin
            @(negedge clk);
            if (aluBus.aluDone) doneSeen++;
        end
        checkOutput("abort.noDone", doneSeen, 0);

        // Illegal op, then a legal op clears the error
        applyStimulus(4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 10, lat);
        checkOutput("ill13.lat", lat, 1);
        checkFlags("ill13", 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd0, 32'd2, 32'd3, 1'b0, 10, lat);
        checkFlags("ill13.clear", 32'd5, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
